// File: rtl/alu_div_seq_pkg.sv
// Shared constants and FSM encoding for the sequential restoring divider.
package alu_div_seq_pkg;
  localparam int          DIV_WIDTH    = 16;
  localparam logic [15:0] DIV_DBZ_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } div_state_t;
endpackage

// File: rtl/FullSubtractor16bit.sv
// Registered 16-bit subtractor shared with the ALU; diff/bout appear one cycle after a/b/bin.
module FullSubtractor16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic [15:0] diff,
  output logic        bout
);
  logic [16:0] res;

  // Widening to 17 bits makes bit 16 the borrow out of the 16-bit subtraction.
  assign res = {1'b0, a} - {1'b0, b} - {16'd0, bin};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      diff <= '0;
      bout <= 1'b0;
    end else begin
      diff <= res[15:0];
      bout <= res[16];
    end
  end
endmodule

// File: rtl/alu_div_seq.sv
// Sequential unsigned restoring divider; one trial subtraction per quotient bit is issued
// to the external registered subtractor and its result consumed one cycle later.
module alu_div_seq
  import alu_div_seq_pkg::*;
#(
  parameter int          WIDTH    = DIV_WIDTH,
  parameter logic [15:0] DBZ_QUOT = DIV_DBZ_QUOT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  output logic             sub_bin,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_bout
);
  localparam int CW = $clog2(WIDTH);

  div_state_t     state, state_nx;
  logic [WIDTH-1:0] rem_r, dvd_r, dsr_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_nx, dvd_nx;
  logic             accept;

  assign sub_a   = {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
  assign sub_b   = dsr_r;
  assign sub_bin = 1'b0;
  assign busy    = (state == S_ISSUE) || (state == S_WAIT);
  assign done    = (state == S_DONE);

  // A set rem_r msb means the true minuend has WIDTH+1 bits and always exceeds the divisor,
  // so the wrapped difference is still the exact remainder.
  assign accept = rem_r[WIDTH-1] | ~sub_bout;
  assign rem_nx = accept ? sub_diff : sub_a;
  assign dvd_nx = {dvd_r[WIDTH-2:0], accept};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (divisor == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  state_nx = (cnt == '0) ? S_DONE : S_ISSUE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_r       <= '0;
      dvd_r       <= '0;
      dsr_r       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          dvd_r       <= dividend;
          dsr_r       <= divisor;
          rem_r       <= '0;
          cnt         <= CW'(WIDTH - 1);
          div_by_zero <= 1'b0;
          if (divisor == '0) begin
            quotient    <= DBZ_QUOT[WIDTH-1:0];
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        S_WAIT: begin
          rem_r <= rem_nx;
          dvd_r <= dvd_nx;
          if (cnt == '0) begin
            quotient  <= dvd_nx;
            remainder <= rem_nx;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq wired to the registered subtractor.
module tb_alu_div_seq;
  import alu_div_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        busy, done, div_by_zero, sub_bin, sub_bout;
  logic [15:0] quotient, remainder, sub_a, sub_b, sub_diff;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  alu_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .sub_a(sub_a), .sub_b(sub_b), .sub_bin(sub_bin),
    .sub_diff(sub_diff), .sub_bout(sub_bout)
  );

  FullSubtractor16bit u_sub (
    .clk(clk), .rst(rst), .a(sub_a), .b(sub_b), .bin(sub_bin),
    .diff(sub_diff), .bout(sub_bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done");
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", {16'd0, quotient}, {16'd0, mon_e.q});
        chk("remainder", {16'd0, remainder}, {16'd0, mon_e.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // ign > 0: present a competing 9/3 start that many cycles into the division.
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                     input logic [15:0] er, input logic edbz, input int ign);
    int k;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back('{eq, er, edbz, cyc + 1 + ((b == 16'd0) ? 0 : 32)});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, {31'd0, (b != 16'd0)});
    k = 0;
    while (!done && k < 80) begin
      @(negedge clk);
      k++;
      if (k == ign) begin
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", {16'd0, quotient}, 32'd0);
    chk("rst_rem", {16'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_sub_a", {16'd0, sub_a}, 32'd0);
    chk("rst_sub_b", {16'd0, sub_b}, 32'd0);
    rst = 1'b1;

    run(16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 0);
    run(16'd65535, 16'd1,     16'd65535, 16'd0,     1'b0, 0);
    run(16'd50000, 16'd60000, 16'd0,     16'd50000, 1'b0, 0);
    run(16'd65535, 16'd40000, 16'd1,     16'd25535, 1'b0, 0);
    run(16'd65535, 16'd65535, 16'd1,     16'd0,     1'b0, 0);
    run(16'd1234,  16'd0,     16'hFFFF,  16'd1234,  1'b1, 0);
    run(16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 5);
    run(16'd9,     16'd3,     16'd3,     16'd0,     1'b0, 0);

    // Abort a division with reset; nothing of it may survive.
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd100;
    divisor  = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quot", {16'd0, quotient}, 32'd0);
    chk("midrst_rem", {16'd0, remainder}, 32'd0);
    chk("midrst_sub_a", {16'd0, sub_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
